// File: rtl/fetch_port_arbiter_if.sv
// Bus between the fetch controller, the shared memory read port and the
// weight / IF tile buffers. The arbiter connects through the slave modport.
interface fetch_port_arbiter_if #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64,
    parameter int W_BEATS  = 8,
    parameter int IF_BEATS = 8
);
    localparam int W_AW  = (W_BEATS  > 1) ? $clog2(W_BEATS)  : 1;
    localparam int IF_AW = (IF_BEATS > 1) ? $clog2(IF_BEATS) : 1;

    logic              clr_w;
    logic              clr_if;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] if_base;
    logic              w_read;
    logic              if_read;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              w_we;
    logic [W_AW-1:0]   w_waddr;
    logic              if_we;
    logic [IF_AW-1:0]  if_waddr;
    logic [DATA_W-1:0] buf_wdata;
    logic              w_done;
    logic              if_done;

    modport master (
        output clr_w, clr_if, w_base, if_base, w_read, if_read, mem_rdata,
        input  mem_req, mem_addr, w_we, w_waddr, if_we, if_waddr, buf_wdata,
               w_done, if_done
    );

    modport slave (
        input  clr_w, clr_if, w_base, if_base, w_read, if_read, mem_rdata,
        output mem_req, mem_addr, w_we, w_waddr, if_we, if_waddr, buf_wdata,
               w_done, if_done
    );
endinterface

// File: rtl/fetch_port_arbiter.sv
// Shares one fixed-latency memory read port between the weight and IF tile
// fetch streams: round-robin beat arbitration, address generation, and
// routing of returned data to the owning tile buffer. Each stream carries an
// epoch bit so beats still in flight across a clr are recognised and dropped.
module fetch_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64,
    parameter int W_BEATS  = 8,
    parameter int IF_BEATS = 8,
    parameter int RD_LAT   = 2
) (
    input logic                clk,
    input logic                rst,
    fetch_port_arbiter_if.slave bus
);
    localparam int W_AW  = (W_BEATS  > 1) ? $clog2(W_BEATS)  : 1;
    localparam int IF_AW = (IF_BEATS > 1) ? $clog2(IF_BEATS) : 1;
    localparam int W_CW  = $clog2(W_BEATS + 1);
    localparam int IF_CW = $clog2(IF_BEATS + 1);
    localparam int IDX_W = (W_AW > IF_AW) ? W_AW : IF_AW;

    typedef struct packed {
        logic             valid;
        logic             sel;    // 0 = weight, 1 = IF
        logic             epoch;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [ADDR_W-1:0] w_base_q, if_base_q;
    logic [W_CW-1:0]   w_issue, w_ret;
    logic [IF_CW-1:0]  if_issue, if_ret;
    logic              w_epoch, if_epoch;
    logic              w_done_q, if_done_q;
    logic              last_if;
    tag_t              tag_pipe [RD_LAT];

    logic w_elig, if_elig, w_gnt, if_gnt;
    logic w_hit, if_hit;
    tag_t tag_new, tag_out;

    // Eligibility, round-robin grant and address/tag for the granted beat.
    // rst gates the grant so the read strobe drops as soon as reset asserts.
    always_comb begin
        w_elig  = !rst && bus.w_read  && (w_issue  < W_CW'(W_BEATS))  && !bus.clr_w;
        if_elig = !rst && bus.if_read && (if_issue < IF_CW'(IF_BEATS)) && !bus.clr_if;
        w_gnt   = w_elig && (!if_elig || last_if);
        if_gnt  = if_elig && !w_gnt;

        bus.mem_req  = w_gnt || if_gnt;
        bus.mem_addr = '0;
        tag_new      = '0;
        if (w_gnt) begin
            bus.mem_addr  = w_base_q + ADDR_W'(w_issue);
            tag_new.valid = 1'b1;
            tag_new.sel   = 1'b0;
            tag_new.epoch = w_epoch;
            tag_new.idx   = IDX_W'(w_issue[W_AW-1:0]);
        end else if (if_gnt) begin
            bus.mem_addr  = if_base_q + ADDR_W'(if_issue);
            tag_new.valid = 1'b1;
            tag_new.sel   = 1'b1;
            tag_new.epoch = if_epoch;
            tag_new.idx   = IDX_W'(if_issue[IF_AW-1:0]);
        end
    end

    // Route the returning beat; stale epochs and same-cycle clr drop it.
    always_comb begin
        tag_out       = tag_pipe[RD_LAT-1];
        w_hit         = tag_out.valid && !tag_out.sel && (tag_out.epoch == w_epoch)  && !bus.clr_w;
        if_hit        = tag_out.valid &&  tag_out.sel && (tag_out.epoch == if_epoch) && !bus.clr_if;
        bus.w_we      = w_hit;
        bus.if_we     = if_hit;
        bus.w_waddr   = tag_out.idx[W_AW-1:0];
        bus.if_waddr  = tag_out.idx[IF_AW-1:0];
        bus.buf_wdata = bus.mem_rdata;
        bus.w_done    = w_done_q;
        bus.if_done   = if_done_q;
    end

    // Tag shift register aligned to the memory latency, and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
            last_if <= 1'b1;
        end else begin
            tag_pipe[0] <= tag_new;
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (w_gnt || if_gnt) last_if <= if_gnt;
        end
    end

    // Weight stream: base, issue/return counters, epoch and done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_base_q <= '0;
            w_issue  <= '0;
            w_ret    <= '0;
            w_epoch  <= 1'b0;
            w_done_q <= 1'b0;
        end else if (bus.clr_w) begin
            w_base_q <= bus.w_base;
            w_issue  <= '0;
            w_ret    <= '0;
            w_epoch  <= ~w_epoch;
            w_done_q <= 1'b0;
        end else begin
            if (w_gnt) w_issue <= w_issue + 1'b1;
            if (w_hit) begin
                w_ret <= w_ret + 1'b1;
                if (w_ret == W_CW'(W_BEATS - 1)) w_done_q <= 1'b1;
            end
        end
    end

    // IF stream: base, issue/return counters, epoch and done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_base_q <= '0;
            if_issue  <= '0;
            if_ret    <= '0;
            if_epoch  <= 1'b0;
            if_done_q <= 1'b0;
        end else if (bus.clr_if) begin
            if_base_q <= bus.if_base;
            if_issue  <= '0;
            if_ret    <= '0;
            if_epoch  <= ~if_epoch;
            if_done_q <= 1'b0;
        end else begin
            if (if_gnt) if_issue <= if_issue + 1'b1;
            if (if_hit) begin
                if_ret <= if_ret + 1'b1;
                if (if_ret == IF_CW'(IF_BEATS - 1)) if_done_q <= 1'b1;
            end
        end
    end
endmodule
